id_ex_scoreboard: RTL and testbench

- ID→EX pipeline register with an integrated register scoreboard. Sits between decode/register-file read and the execute stage.
- Tracks outstanding writes to each of the 16 architectural registers, stalls decode on RAW hazards, and captures operands plus control into the EX stage.
- Consumes the same write-back signals (enable, destination) that drive register-file writes, so scoreboard entries retire exactly when the register file is updated.

---
 rtl/id_ex_scoreboard_pkg.sv | 33 +++
 rtl/id_ex_scoreboard_if.sv | 43 ++++
 rtl/id_ex_scoreboard_sb.sv | 79 +++++++
 rtl/id_ex_scoreboard.sv | 100 ++++++++++
 tb/tb_id_ex_scoreboard.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_scoreboard_pkg.sv
// Shared ARM-pipeline types: register indices, data words and the decoded control bundle.
// No logic; constants and typedefs only.
// Imported by the scoreboard, its interface and the bench.
package arm_pipe_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NREG      = 16;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = 2;
    localparam int CTRL_W    = 9;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // Highest count a register can reach before decode must stall on a new writer.
    localparam cnt_t CNT_MAX = '1;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r;
        logic       mem_w;
        logic       wb_en;
        logic       s;
        logic       b;
    } ctrl_t;

    // True when an enabled access targets the given register.
    function automatic logic reg_hit(input logic en, input reg_idx_t a, input reg_idx_t b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/id_ex_scoreboard_if.sv
// Decode/write-back/EX signal bundle for the ID->EX stage with its scoreboard.
// No latency of its own; plain wires.
// The stage only throttles decode through id_stall; write-back is never held off.
interface id_ex_scoreboard_if;
    import arm_pipe_pkg::*;

    logic     id_valid;
    reg_idx_t id_src1;
    reg_idx_t id_src2;
    logic     id_two_src;
    logic     id_wb_en;
    reg_idx_t id_dest;
    word_t    id_val1;
    word_t    id_val2;
    ctrl_t    id_ctrl;
    logic     freeze;
    logic     flush;
    logic     wb_en;
    reg_idx_t wb_dest;

    logic     id_stall;
    logic     ex_valid;
    logic     ex_wb_en;
    reg_idx_t ex_dest;
    word_t    ex_val1;
    word_t    ex_val2;
    ctrl_t    ex_ctrl;

    // Pipeline side: decode, hazard control and write-back drive the stage.
    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
               id_val1, id_val2, id_ctrl, freeze, flush, wb_en, wb_dest,
        input  id_stall, ex_valid, ex_wb_en, ex_dest, ex_val1, ex_val2, ex_ctrl
    );

    // Stage side.
    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
               id_val1, id_val2, id_ctrl, freeze, flush, wb_en, wb_dest,
        output id_stall, ex_valid, ex_wb_en, ex_dest, ex_val1, ex_val2, ex_ctrl
    );

endinterface

// File: rtl/id_ex_scoreboard_sb.sv
// Per-register outstanding-write counters with RAW and saturation hazard detection.
// Hazard output is combinational; counters update one cycle after issue/retire/flush.
// Never stalls itself; decode is held via hazard_o when a source is pending or dest is full.
module reg_scoreboard
    import arm_pipe_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t src1_i,
    input  reg_idx_t src2_i,
    input  logic     two_src_i,
    input  logic     id_wb_en_i,
    input  reg_idx_t dest_i,
    input  logic     issue_i,
    input  logic     wb_en_i,
    input  reg_idx_t wb_dest_i,
    input  logic     flush_i,
    input  logic     ex_valid_i,
    input  logic     ex_wb_en_i,
    input  reg_idx_t ex_dest_i,
    output logic     hazard_o
);

    cnt_t           cnt_q [NREG];
    cnt_t           cnt_d [NREG];
    logic [NREG-1:0] uf;

    logic ret1;
    logic ret2;
    logic haz1;
    logic haz2;
    logic sat;

    // A write-back this cycle is already visible in the register file, so it clears the hazard.
    always_comb begin
        ret1     = reg_hit(wb_en_i, wb_dest_i, src1_i);
        ret2     = reg_hit(wb_en_i, wb_dest_i, src2_i);
        haz1     = cnt_q[src1_i] > cnt_t'(ret1);
        haz2     = two_src_i && (cnt_q[src2_i] > cnt_t'(ret2));
        sat      = id_wb_en_i && (cnt_q[dest_i] == CNT_MAX);
        hazard_o = haz1 || haz2 || sat;
    end

    // Next count = cnt + inc - retire - flush rollback, clamped at zero on underflow.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic [CNT_W:0] up;
            logic [CNT_W:0] dn;
            up = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, issue_i && reg_hit(id_wb_en_i, dest_i, reg_idx_t'(r))};
            dn = {{CNT_W{1'b0}}, reg_hit(wb_en_i, wb_dest_i, reg_idx_t'(r))}
               + {{CNT_W{1'b0}}, flush_i && ex_valid_i && reg_hit(ex_wb_en_i, ex_dest_i, reg_idx_t'(r))};
            if (up < dn) begin
                cnt_d[r] = '0;
                uf[r]    = 1'b1;
            end else begin
                cnt_d[r] = cnt_t'(up - dn);
                uf[r]    = 1'b0;
            end
        end
    end

    // Counter array register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // A retire or rollback with nothing outstanding means the pipeline lost track of a write.
    always @(posedge clk) begin
        if (rst) begin
            assert (uf == '0)
                else $error("reg_scoreboard: counter underflow, mask=%h", uf);
        end
    end

endmodule

// File: rtl/id_ex_scoreboard.sv
// ID->EX pipeline register with integrated outstanding-write scoreboard.
// One cycle ID to EX; id_stall is combinational from the current counters.
// Priority flush > freeze > issue > bubble; freeze holds EX and stalls decode.
module id_ex_scoreboard
    import arm_pipe_pkg::*;
(
    input logic               clk,
    input logic               rst,
    id_ex_scoreboard_if.slave bus
);

    logic     hazard;
    logic     stall;
    logic     issue;

    logic     ex_valid_q, ex_valid_d;
    logic     ex_wb_en_q, ex_wb_en_d;
    reg_idx_t ex_dest_q,  ex_dest_d;
    word_t    ex_val1_q,  ex_val1_d;
    word_t    ex_val2_q,  ex_val2_d;
    ctrl_t    ex_ctrl_q,  ex_ctrl_d;

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .src1_i     (bus.id_src1),
        .src2_i     (bus.id_src2),
        .two_src_i  (bus.id_two_src),
        .id_wb_en_i (bus.id_wb_en),
        .dest_i     (bus.id_dest),
        .issue_i    (issue),
        .wb_en_i    (bus.wb_en),
        .wb_dest_i  (bus.wb_dest),
        .flush_i    (bus.flush),
        .ex_valid_i (ex_valid_q),
        .ex_wb_en_i (ex_wb_en_q),
        .ex_dest_i  (ex_dest_q),
        .hazard_o   (hazard)
    );

    // Stall and issue decision; flush kills the ID instruction so decode need not hold.
    always_comb begin
        stall = bus.id_valid && (hazard || bus.freeze) && !bus.flush;
        issue = bus.id_valid && !stall && !bus.flush && !bus.freeze;
    end

    // EX register next state in priority order.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_wb_en_d = ex_wb_en_q;
        ex_dest_d  = ex_dest_q;
        ex_val1_d  = ex_val1_q;
        ex_val2_d  = ex_val2_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_wb_en_d = 1'b0;
        end else if (bus.freeze) begin
            ex_valid_d = ex_valid_q;
        end else if (issue) begin
            ex_valid_d = 1'b1;
            ex_wb_en_d = bus.id_wb_en;
            ex_dest_d  = bus.id_dest;
            ex_val1_d  = bus.id_val1;
            ex_val2_d  = bus.id_val2;
            ex_ctrl_d  = bus.id_ctrl;
        end else begin
            ex_valid_d = 1'b0;
            ex_wb_en_d = 1'b0;
        end
    end

    // EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_wb_en_q <= 1'b0;
            ex_dest_q  <= '0;
            ex_val1_q  <= '0;
            ex_val2_q  <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_wb_en_q <= ex_wb_en_d;
            ex_dest_q  <= ex_dest_d;
            ex_val1_q  <= ex_val1_d;
            ex_val2_q  <= ex_val2_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign bus.id_stall = stall;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_wb_en = ex_wb_en_q;
    assign bus.ex_dest  = ex_dest_q;
    assign bus.ex_val1  = ex_val1_q;
    assign bus.ex_val2  = ex_val2_q;
    assign bus.ex_ctrl  = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_scoreboard.sv
// Directed bench for id_ex_scoreboard: reset, issue, RAW stall, src2 gating, flush, saturation, freeze.
// Inputs change 1 ns after posedge; combinational outputs checked 1 ns later, registers after the next edge.
module tb_id_ex_scoreboard;
    import arm_pipe_pkg::*;

    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;

    id_ex_scoreboard_if sb_if ();

    id_ex_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic vld, input reg_idx_t s1, input reg_idx_t s2, input logic two,
                            input logic wben, input reg_idx_t dst, input word_t v1, input word_t v2);
        sb_if.id_valid   = vld;
        sb_if.id_src1    = s1;
        sb_if.id_src2    = s2;
        sb_if.id_two_src = two;
        sb_if.id_wb_en   = wben;
        sb_if.id_dest    = dst;
        sb_if.id_val1    = v1;
        sb_if.id_val2    = v2;
    endtask

    task automatic drive_wb(input logic en, input reg_idx_t dst);
        sb_if.wb_en   = en;
        sb_if.wb_dest = dst;
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b0;
        drive_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        sb_if.id_ctrl = '0;
        sb_if.freeze  = 1'b0;
        sb_if.flush   = 1'b0;
        drive_wb(1'b0, 4'd0);

        // Reset state
        #2;
        check_eq("rst_ex_valid", sb_if.ex_valid, 0);
        check_eq("rst_ex_val1",  sb_if.ex_val1, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("rst_cnt1", dut.u_sb.cnt_q[1], 0);
        check_eq("rst_ex_valid_idle", sb_if.ex_valid, 0);

        // Issue ADD R1
        drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 32'h0000_1111, 32'h0000_2222);
        sb_if.id_ctrl = 9'h1A5;
        #1;
        check_eq("add_stall", sb_if.id_stall, 0);
        tick();
        check_eq("add_ex_valid", sb_if.ex_valid, 1);
        check_eq("add_ex_dest",  sb_if.ex_dest, 1);
        check_eq("add_ex_val2",  sb_if.ex_val2, 32'h0000_2222);
        check_eq("add_ex_ctrl",  sb_if.ex_ctrl, 9'h1A5);
        check_eq("add_cnt1",     dut.u_sb.cnt_q[1], 1);

        // RAW stall: SUB R6 <- R1
        drive_id(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd6, 32'h0, 32'h0);
        #1;
        check_eq("raw_stall0", sb_if.id_stall, 1);
        tick();
        check_eq("raw_stall1", sb_if.id_stall, 1);
        check_eq("raw_bubble", sb_if.ex_valid, 0);
        tick();
        check_eq("raw_stall2", sb_if.id_stall, 1);
        drive_wb(1'b1, 4'd1);
        #1;
        check_eq("raw_wb_release", sb_if.id_stall, 0);
        tick();
        drive_wb(1'b0, 4'd0);
        drive_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        check_eq("raw_issued", sb_if.ex_dest, 6);
        check_eq("raw_cnt1",   dut.u_sb.cnt_q[1], 0);
        check_eq("raw_cnt6",   dut.u_sb.cnt_q[6], 1);

        // Operand-2 gating on R5
        drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 32'h0, 32'h0);
        tick();
        drive_id(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        #1;
        check_eq("src2_ungated", sb_if.id_stall, 0);
        sb_if.id_two_src = 1'b1;
        #1;
        check_eq("src2_gated", sb_if.id_stall, 1);
        sb_if.id_valid = 1'b0;
        drive_wb(1'b1, 4'd5);
        tick();
        drive_wb(1'b1, 4'd6);
        tick();
        drive_wb(1'b0, 4'd0);
        check_eq("src2_cnt5", dut.u_sb.cnt_q[5], 0);
        check_eq("src2_cnt6", dut.u_sb.cnt_q[6], 0);

        // Flush rollback
        drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 32'h0, 32'h0);
        tick();
        check_eq("fl_cnt3_pre", dut.u_sb.cnt_q[3], 1);
        drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 32'h0, 32'h0);
        sb_if.flush = 1'b1;
        #1;
        check_eq("fl_stall", sb_if.id_stall, 0);
        tick();
        sb_if.flush = 1'b0;
        sb_if.id_valid = 1'b0;
        check_eq("fl_ex_valid", sb_if.ex_valid, 0);
        check_eq("fl_cnt3", dut.u_sb.cnt_q[3], 0);
        check_eq("fl_cnt4", dut.u_sb.cnt_q[4], 0);

        // Simultaneous inc/dec, then saturation on R2
        drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 32'h0, 32'h0);
        tick();
        drive_wb(1'b1, 4'd2);
        tick();
        drive_wb(1'b0, 4'd0);
        check_eq("incdec_cnt2", dut.u_sb.cnt_q[2], 1);
        tick();
        tick();
        check_eq("sat_cnt2_full", dut.u_sb.cnt_q[2], 3);
        #1;
        check_eq("sat_stall0", sb_if.id_stall, 1);
        tick();
        check_eq("sat_stall1", sb_if.id_stall, 1);
        check_eq("sat_hold_cnt", dut.u_sb.cnt_q[2], 3);
        drive_wb(1'b1, 4'd2);
        tick();
        drive_wb(1'b0, 4'd0);
        check_eq("sat_retired", dut.u_sb.cnt_q[2], 2);
        #1;
        check_eq("sat_release", sb_if.id_stall, 0);
        tick();
        sb_if.id_valid = 1'b0;
        check_eq("sat_refill", dut.u_sb.cnt_q[2], 3);
        drive_wb(1'b1, 4'd2);
        for (int i = 0; i < 3; i++) tick();
        drive_wb(1'b0, 4'd0);
        check_eq("sat_drain", dut.u_sb.cnt_q[2], 0);

        // Freeze: EX holds while a write-back still retires
        drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd7, 32'hDEAD_BEEF, 32'h0);
        tick();
        check_eq("frz_ex_val1", sb_if.ex_val1, 32'hDEAD_BEEF);
        drive_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd8, 32'h1234_5678, 32'h0);
        sb_if.freeze = 1'b1;
        #1;
        check_eq("frz_stall", sb_if.id_stall, 1);
        for (int i = 0; i < 3; i++) begin
            drive_wb(i == 1, 4'd7);
            tick();
            check_eq("frz_hold_val1", sb_if.ex_val1, 32'hDEAD_BEEF);
            check_eq("frz_hold_valid", sb_if.ex_valid, 1);
        end
        drive_wb(1'b0, 4'd0);
        check_eq("frz_cnt7", dut.u_sb.cnt_q[7], 0);
        check_eq("frz_cnt8", dut.u_sb.cnt_q[8], 0);
        sb_if.freeze = 1'b0;
        #1;
        check_eq("frz_release", sb_if.id_stall, 0);
        tick();
        sb_if.id_valid = 1'b0;
        check_eq("frz_issue_val1", sb_if.ex_val1, 32'h1234_5678);
        check_eq("frz_cnt8_post", dut.u_sb.cnt_q[8], 1);

        // Reset mid-stall
        drive_id(1'b1, 4'd8, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
        #1;
        check_eq("mid_rst_stall", sb_if.id_stall, 1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_release", sb_if.id_stall, 0);
        check_eq("mid_rst_ex_valid", sb_if.ex_valid, 0);
        check_eq("mid_rst_cnt8", dut.u_sb.cnt_q[8], 0);
        sb_if.id_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
